// File: rtl/mips_decode_pkg.sv
// Opcode/funct encodings, ALU operation codes and the decoded control bundle
// shared by the decode stage and its combinational decoder.
package mips_decode_pkg;

   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ANDI    = 6'h0c;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_XORI    = 6'h0e;

   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;

   localparam logic [2:0] ALU_NONE   = 3'd0;
   localparam logic [2:0] ALU_ADD    = 3'd2;
   localparam logic [2:0] ALU_SUB    = 3'd3;
   localparam logic [2:0] ALU_AND    = 3'd4;
   localparam logic [2:0] ALU_OR     = 3'd5;
   localparam logic [2:0] ALU_NOR    = 3'd6;
   localparam logic [2:0] ALU_XOR    = 3'd7;

   // The immediate is kept as its raw 16 bits plus a sign-extend flag so the
   // queue width does not depend on IMM_W; extension happens at the output.
   typedef struct packed {
      logic [2:0]  alu_op;
      logic        rd_src;
      logic        alu_src2;
      logic        writeenable;
      logic        except;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm16;
      logic        imm_sext;
   } bundle_t;

endpackage

// File: rtl/mips_decode_pipe_if.sv
// Instruction-in / control-bundle-out handshake bus of the decode stage.
interface mips_decode_pipe_if #(parameter int IMM_W = 32);

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       alu_op;
   logic             rd_src;
   logic             alu_src2;
   logic             writeenable;
   logic             except;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic [IMM_W-1:0] imm;

   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, alu_op, rd_src, alu_src2, writeenable,
             except, rs, rt, rd, imm
   );

   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, alu_op, rd_src, alu_src2, writeenable,
             except, rs, rt, rd, imm
   );

endinterface

// File: rtl/mips_decode_comb.sv
// Pure combinational MIPS arithmetic decoder: instruction word to control bundle.
module mips_decode_comb
   import mips_decode_pkg::*;
(
   input  logic [31:0] instr,
   output bundle_t     bundle
);

   // Opcode/funct decode; unrecognised encodings collapse to the exception bundle
   always_comb begin
      bundle          = '0;
      bundle.rs       = instr[25:21];
      bundle.rt       = instr[20:16];
      bundle.rd       = instr[15:11];
      case (instr[31:26])
         OP_RTYPE: begin
            case (instr[5:0])
               FUNCT_ADD: bundle.alu_op = ALU_ADD;
               FUNCT_SUB: bundle.alu_op = ALU_SUB;
               FUNCT_AND: bundle.alu_op = ALU_AND;
               FUNCT_OR:  bundle.alu_op = ALU_OR;
               FUNCT_NOR: bundle.alu_op = ALU_NOR;
               FUNCT_XOR: bundle.alu_op = ALU_XOR;
               default:   bundle.except = 1'b1;
            endcase
         end
         OP_ADDI: begin
            bundle.alu_op   = ALU_ADD;
            bundle.imm16    = instr[15:0];
            bundle.imm_sext = 1'b1;
         end
         OP_ANDI: begin
            bundle.alu_op = ALU_AND;
            bundle.imm16  = instr[15:0];
         end
         OP_ORI: begin
            bundle.alu_op = ALU_OR;
            bundle.imm16  = instr[15:0];
         end
         OP_XORI: begin
            bundle.alu_op = ALU_XOR;
            bundle.imm16  = instr[15:0];
         end
         default: bundle.except = 1'b1;
      endcase

      if (bundle.except) begin
         bundle.alu_op      = ALU_NONE;
         bundle.writeenable = 1'b0;
         bundle.rd_src      = 1'b1;
         bundle.alu_src2    = 1'b1;
         bundle.imm16       = 16'h0000;
         bundle.imm_sext    = 1'b0;
      end else begin
         bundle.writeenable = 1'b1;
         bundle.rd_src      = (instr[31:26] != OP_RTYPE);
         bundle.alu_src2    = (instr[31:26] != OP_RTYPE);
      end
   end

endmodule

// File: rtl/mips_decode_pipe.sv
// Registered MIPS arithmetic decode stage: decode on accept, DEPTH-entry output
// queue with valid/ready on both sides, and exception count/capture.
module mips_decode_pipe
   import mips_decode_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8,
   parameter int IMM_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              exc_clear,
   mips_decode_pipe_if.slave bus,
   output logic [CNT_W-1:0]  exc_count,
   output logic              exc_seen,
   output logic [31:0]       exc_instr
);

   localparam int CQ_W  = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   bundle_t          dec_s;
   bundle_t          q_r [DEPTH];
   bundle_t          out_r;
   bundle_t          head_nx_s;
   logic [CQ_W-1:0]  count_r;
   logic [CQ_W-1:0]  count_nx_s;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_nx_s;
   logic [PTR_W-1:0] rd_nx_s;
   logic             out_valid_r;
   logic             push_s;
   logic             pop_s;
   logic             exc_acc_s;
   logic [CNT_W-1:0] exc_count_r;
   logic             exc_seen_r;
   logic [31:0]      exc_instr_r;
   logic [IMM_W-1:0] imm_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + 1'b1;
   endfunction

   mips_decode_comb u_dec (
      .instr  (bus.instr),
      .bundle (dec_s)
   );

   assign bus.in_ready = (count_r < CQ_W'(DEPTH)) || bus.out_ready;
   assign push_s       = bus.in_valid && bus.in_ready && !flush;
   assign pop_s        = out_valid_r && bus.out_ready && !flush;
   assign exc_acc_s    = push_s && dec_s.except;

   // Next queue state; the output register is preloaded with the next head so
   // that it always mirrors the head and holds the last popped entry when empty
   always_comb begin
      count_nx_s = count_r;
      rd_nx_s    = rd_ptr_r;
      wr_nx_s    = wr_ptr_r;
      head_nx_s  = out_r;
      if (flush) begin
         count_nx_s = {CQ_W{1'b0}};
         rd_nx_s    = {PTR_W{1'b0}};
         wr_nx_s    = {PTR_W{1'b0}};
      end else begin
         rd_nx_s    = pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
         wr_nx_s    = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
         count_nx_s = count_r + CQ_W'(push_s) - CQ_W'(pop_s);
         if (count_nx_s == {CQ_W{1'b0}}) begin
            head_nx_s = out_r;
         end else if (count_r == CQ_W'(pop_s)) begin
            head_nx_s = dec_s;
         end else begin
            head_nx_s = q_r[rd_nx_s];
         end
      end
   end

   // Queue storage, pointers, occupancy and head register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_r[i] <= '0;
         end
         count_r     <= {CQ_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         wr_ptr_r    <= {PTR_W{1'b0}};
         out_r       <= '0;
         out_valid_r <= 1'b0;
      end else begin
         if (push_s) begin
            q_r[wr_ptr_r] <= dec_s;
         end
         count_r     <= count_nx_s;
         rd_ptr_r    <= rd_nx_s;
         wr_ptr_r    <= wr_nx_s;
         out_r       <= head_nx_s;
         out_valid_r <= (count_nx_s != {CQ_W{1'b0}});
      end
   end

   // Exception counter, sticky flag and first-offender capture; clear wins
   // over history but not over an exception accepted in the same cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exc_count_r <= {CNT_W{1'b0}};
         exc_seen_r  <= 1'b0;
         exc_instr_r <= 32'h0000_0000;
      end else if (exc_clear) begin
         exc_count_r <= exc_acc_s ? CNT_W'(1) : {CNT_W{1'b0}};
         exc_seen_r  <= exc_acc_s;
         exc_instr_r <= exc_acc_s ? bus.instr : 32'h0000_0000;
      end else if (exc_acc_s) begin
         if (exc_count_r != {CNT_W{1'b1}}) begin
            exc_count_r <= exc_count_r + 1'b1;
         end
         if (!exc_seen_r) begin
            exc_seen_r  <= 1'b1;
            exc_instr_r <= bus.instr;
         end
      end
   end

   // Immediate extension of the registered head entry
   always_comb begin
      if (out_r.imm_sext) begin
         imm_s = IMM_W'($signed(out_r.imm16));
      end else begin
         imm_s = IMM_W'(out_r.imm16);
      end
   end

   assign bus.out_valid   = out_valid_r;
   assign bus.alu_op      = out_r.alu_op;
   assign bus.rd_src      = out_r.rd_src;
   assign bus.alu_src2    = out_r.alu_src2;
   assign bus.writeenable = out_r.writeenable;
   assign bus.except      = out_r.except;
   assign bus.rs          = out_r.rs;
   assign bus.rt          = out_r.rt;
   assign bus.rd          = out_r.rd;
   assign bus.imm         = imm_s;
   assign exc_count       = exc_count_r;
   assign exc_seen        = exc_seen_r;
   assign exc_instr       = exc_instr_r;

endmodule

// File: tb/tb_mips_decode_pipe.sv
// Directed self-checking bench for mips_decode_pipe (DEPTH=2), with a second
// instance at CNT_W=2 for counter saturation.
module tb_mips_decode_pipe;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        exc_clear = 1'b0;
   logic        flush2 = 1'b0;
   logic        exc_clear2 = 1'b0;
   logic [7:0]  exc_count;
   logic        exc_seen;
   logic [31:0] exc_instr;
   logic [1:0]  exc_count2;
   logic        exc_seen2;
   logic [31:0] exc_instr2;
   int          n_checks = 0;
   int          n_pass = 0;

   mips_decode_pipe_if #(.IMM_W(32)) bus ();
   mips_decode_pipe_if #(.IMM_W(32)) bus2 ();

   mips_decode_pipe #(.DEPTH(2), .CNT_W(8), .IMM_W(32)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush), .exc_clear(exc_clear),
      .bus(bus), .exc_count(exc_count), .exc_seen(exc_seen), .exc_instr(exc_instr)
   );

   mips_decode_pipe #(.DEPTH(2), .CNT_W(2), .IMM_W(32)) dut2 (
      .clock(clock), .reset_n(reset_n), .flush(flush2), .exc_clear(exc_clear2),
      .bus(bus2), .exc_count(exc_count2), .exc_seen(exc_seen2), .exc_instr(exc_instr2)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.instr = 32'h0; bus.out_ready = 1'b0;
      bus2.in_valid = 1'b0; bus2.instr = 32'h0; bus2.out_ready = 1'b1;
      reset_n = 1'b0;
      step(); step();
      reset_n = 1'b1;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0d exp=0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0d exp=1", bus.in_ready); else n_pass++;
      n_checks++; if (bus.alu_op !== 3'd0 || bus.writeenable !== 1'b0 || bus.except !== 1'b0)
         $display("FAIL rst_bundle got alu_op=%0d we=%0d exc=%0d exp 0/0/0", bus.alu_op, bus.writeenable, bus.except); else n_pass++;
      n_checks++; if (bus.imm !== 32'h0 || bus.rd !== 5'd0) $display("FAIL rst_imm_rd got imm=%h rd=%0d exp 0", bus.imm, bus.rd); else n_pass++;
      n_checks++; if (exc_count !== 8'd0 || exc_seen !== 1'b0 || exc_instr !== 32'h0)
         $display("FAIL rst_exc got cnt=%0d seen=%0d instr=%h exp 0", exc_count, exc_seen, exc_instr); else n_pass++;
   endtask

   task automatic test_rtype();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.instr = 32'h012A4020;
      step();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL add_valid got=%0d exp=1", bus.out_valid); else n_pass++;
      n_checks++; if (bus.alu_op !== 3'd2 || bus.rd_src !== 1'b0 || bus.alu_src2 !== 1'b0 || bus.writeenable !== 1'b1 || bus.except !== 1'b0)
         $display("FAIL add_ctrl got op=%0d rdsrc=%0d src2=%0d we=%0d exc=%0d exp 2/0/0/1/0",
                  bus.alu_op, bus.rd_src, bus.alu_src2, bus.writeenable, bus.except); else n_pass++;
      n_checks++; if (bus.rs !== 5'd9 || bus.rt !== 5'd10 || bus.rd !== 5'd8 || bus.imm !== 32'h0)
         $display("FAIL add_regs got rs=%0d rt=%0d rd=%0d imm=%h exp 9/10/8/0", bus.rs, bus.rt, bus.rd, bus.imm); else n_pass++;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL add_pop_valid got=%0d exp=0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.alu_op !== 3'd2 || bus.rd !== 5'd8) $display("FAIL add_hold got op=%0d rd=%0d exp 2/8", bus.alu_op, bus.rd); else n_pass++;
   endtask

   task automatic test_itype();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.instr = 32'h2128FFFF;
      step();
      n_checks++; if (bus.imm !== 32'hFFFFFFFF || bus.alu_op !== 3'd2) $display("FAIL addi got imm=%h op=%0d exp ffffffff/2", bus.imm, bus.alu_op); else n_pass++;
      n_checks++; if (bus.rd_src !== 1'b1 || bus.alu_src2 !== 1'b1 || bus.writeenable !== 1'b1 || bus.rt !== 5'd8)
         $display("FAIL addi_ctrl got rdsrc=%0d src2=%0d we=%0d rt=%0d exp 1/1/1/8", bus.rd_src, bus.alu_src2, bus.writeenable, bus.rt); else n_pass++;
      bus.instr = 32'h3528FFFF; bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.imm !== 32'h0000FFFF || bus.alu_op !== 3'd5)
         $display("FAIL ori got v=%0d imm=%h op=%0d exp 1/0000ffff/5", bus.out_valid, bus.imm, bus.alu_op); else n_pass++;
      step();
      bus.out_ready = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL ori_drain got=%0d exp=0", bus.out_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] pushes [3];
      logic [2:0]  ops [5];
      pushes = '{32'h012A4024, 32'h012A4025, 32'h012A4027};
      ops    = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.instr = 32'h012A4020;
      step();
      bus.instr = 32'h012A4022;
      step();
      bus.instr = pushes[0];
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready got=%0d exp=0", bus.in_ready); else n_pass++;
      step();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_op !== 3'd2 || bus.in_ready !== 1'b0)
         $display("FAIL full_stable got v=%0d op=%0d rdy=%0d exp 1/2/0", bus.out_valid, bus.alu_op, bus.in_ready); else n_pass++;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = (k < 3);
         if (k < 3) bus.instr = pushes[k];
         #1;
         n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_op !== ops[k] || bus.in_ready !== 1'b1)
            $display("FAIL stream_%0d got v=%0d op=%0d rdy=%0d exp 1/%0d/1", k, bus.out_valid, bus.alu_op, bus.in_ready, ops[k]); else n_pass++;
         step();
      end
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL stream_end got=%0d exp=0", bus.out_valid); else n_pass++;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_exceptions();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.instr = 32'h0000003F;
      step();
      n_checks++; if (bus.except !== 1'b1 || bus.writeenable !== 1'b0 || bus.alu_op !== 3'd0)
         $display("FAIL bad_funct got exc=%0d we=%0d op=%0d exp 1/0/0", bus.except, bus.writeenable, bus.alu_op); else n_pass++;
      n_checks++; if (bus.rd_src !== 1'b1 || bus.alu_src2 !== 1'b1 || bus.imm !== 32'h0)
         $display("FAIL bad_funct_ctrl got rdsrc=%0d src2=%0d imm=%h exp 1/1/0", bus.rd_src, bus.alu_src2, bus.imm); else n_pass++;
      bus.instr = 32'hFC000000;
      step();
      bus.in_valid = 1'b0;
      n_checks++; if (exc_count !== 8'd2 || exc_seen !== 1'b1 || exc_instr !== 32'h0000003F)
         $display("FAIL exc_cnt got cnt=%0d seen=%0d instr=%h exp 2/1/0000003f", exc_count, exc_seen, exc_instr); else n_pass++;
      bus.out_ready = 1'b1;
      step();
      n_checks++; if (bus.except !== 1'b1 || bus.alu_op !== 3'd0 || bus.out_valid !== 1'b1)
         $display("FAIL bad_op got exc=%0d op=%0d v=%0d exp 1/0/1", bus.except, bus.alu_op, bus.out_valid); else n_pass++;
      step();
      bus.in_valid = 1'b1; bus.instr = 32'hFC000000; exc_clear = 1'b1;
      step();
      bus.in_valid = 1'b0; exc_clear = 1'b0;
      n_checks++; if (exc_count !== 8'd1 || exc_seen !== 1'b1 || exc_instr !== 32'hFC000000)
         $display("FAIL clr_accept got cnt=%0d seen=%0d instr=%h exp 1/1/fc000000", exc_count, exc_seen, exc_instr); else n_pass++;
      exc_clear = 1'b1;
      step();
      exc_clear = 1'b0;
      step();
      n_checks++; if (exc_count !== 8'd0 || exc_seen !== 1'b0 || exc_instr !== 32'h0)
         $display("FAIL clr_only got cnt=%0d seen=%0d instr=%h exp 0/0/0", exc_count, exc_seen, exc_instr); else n_pass++;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_saturate();
      bus2.out_ready = 1'b1;
      bus2.in_valid = 1'b1; bus2.instr = 32'hFC000000;
      for (int k = 0; k < 5; k++) step();
      bus2.in_valid = 1'b0;
      n_checks++; if (exc_count2 !== 2'd3 || exc_seen2 !== 1'b1 || exc_instr2 !== 32'hFC000000)
         $display("FAIL sat got cnt=%0d seen=%0d instr=%h exp 3/1/fc000000", exc_count2, exc_seen2, exc_instr2); else n_pass++;
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.instr = 32'h012A4020;
      step();
      bus.instr = 32'h012A4022;
      step();
      flush = 1'b1; bus.out_ready = 1'b1; bus.instr = 32'hFC000000;
      step();
      flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0 || exc_count !== 8'd0)
         $display("FAIL flush got v=%0d cnt=%0d exp 0/0", bus.out_valid, exc_count); else n_pass++;
      bus.in_valid = 1'b1; bus.instr = 32'h012A4026;
      step();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_op !== 3'd7)
         $display("FAIL post_flush got v=%0d op=%0d exp 1/7", bus.out_valid, bus.alu_op); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bus.in_valid = 1'b1; bus.instr = 32'hFC000000;
      step();
      bus.in_valid = 1'b0;
      n_checks++; if (exc_count !== 8'd1) $display("FAIL pre_rst_cnt got=%0d exp=1", exc_count); else n_pass++;
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0 || exc_count !== 8'd0 || exc_seen !== 1'b0 || bus.alu_op !== 3'd0)
         $display("FAIL mid_rst got v=%0d cnt=%0d seen=%0d op=%0d exp 0/0/0/0", bus.out_valid, exc_count, exc_seen, bus.alu_op); else n_pass++;
      step();
      reset_n = 1'b1;
      bus.out_ready = 1'b1;
      step();
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL post_rst_valid got=%0d exp=0", bus.out_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_itype();
      test_back_to_back();
      test_exceptions();
      test_saturate();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
